// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned SYS_CLK     = 100_000_000,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned HAS_PARITY  = 0,
    parameter int unsigned PARITY_EVEN = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CLKS_PER_BIT = SYS_CLK / BAUD_RATE;
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 accept;
    logic                 bit_end;
    logic                 frame_end;
    logic                 launch;
    logic [DATA_BITS-1:0] launch_data;
    logic [DATA_BITS-1:0] shift_nx;

`ifdef UART_TX_HOLD_EN
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_vld_q, hold_vld_d;

    assign ready = ~reset & ~hold_vld_q;
`else
    assign ready = ~reset & (state_q == StIdle);
`endif

    assign accept    = valid & ready;
    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = (state_q == StStop) & bit_end & (idx_q == STOP_LAST);
    assign shift_nx  = shift_q >> 1;
    assign tx        = tx_q;
    assign busy      = busy_q;

    // A new frame starts from idle, or straight out of the final stop cycle with no gap.
    always_comb begin
        launch      = 1'b0;
        launch_data = data_in;
`ifdef UART_TX_HOLD_EN
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        if (state_q == StIdle) begin
            launch = accept;
        end else if (frame_end) begin
            if (hold_vld_q) begin
                launch      = 1'b1;
                launch_data = hold_q;
                hold_vld_d  = 1'b0;
            end else begin
                launch = accept;
            end
        end else if (accept) begin
            hold_d     = data_in;
            hold_vld_d = 1'b1;
        end
`else
        launch = accept;
`endif
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;

        // Counter wraps to zero at every bit boundary so timing never accumulates error.
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
                        if (HAS_PARITY != 0) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_nx;
                        tx_d    = shift_nx[0];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (launch) begin
            state_d  = StStart;
            baud_d   = '0;
            idx_d    = '0;
            shift_d  = launch_data;
            parity_d = (PARITY_EVEN != 0) ? ^launch_data : ~^launch_data;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
`ifdef UART_TX_HOLD_EN
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three instances (8N1, 8E1, 8O2) driven with random bytes and gaps,
// line decoded cycle-by-cycle against frames built from the bit-level protocol rules.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned SYS  = 100_000;
    localparam int unsigned BAUD = 7_000;
    localparam int          CPB  = SYS / BAUD;  // 14 cycles per bit
    localparam int          NFR  = 24;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] valid_r;
    logic [7:0] data_r [3];
    wire  [2:0] ready_w;
    wire  [2:0] tx_w;
    wire  [2:0] busy_w;

    longint cyc   = 0;
    int     tests = 0;
    int     fails = 0;

    typedef struct {
        int         k;
        logic [7:0] d;
        longint     acc;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.DATA_BITS(8), .BAUD_RATE(BAUD), .SYS_CLK(SYS), .STOP_BITS(1),
              .HAS_PARITY(0), .PARITY_EVEN(0)) u_dut0 (
        .clk(clk), .reset(reset), .valid(valid_r[0]), .data_in(data_r[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    uart_tx #(.DATA_BITS(8), .BAUD_RATE(BAUD), .SYS_CLK(SYS), .STOP_BITS(1),
              .HAS_PARITY(1), .PARITY_EVEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .valid(valid_r[1]), .data_in(data_r[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    uart_tx #(.DATA_BITS(8), .BAUD_RATE(BAUD), .SYS_CLK(SYS), .STOP_BITS(2),
              .HAS_PARITY(1), .PARITY_EVEN(0)) u_dut2 (
        .clk(clk), .reset(reset), .valid(valid_r[2]), .data_in(data_r[2]),
        .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_bits(input int k);
        return 1 + 8 + ((k != 0) ? 1 : 0) + ((k == 2) ? 2 : 1);
    endfunction

    // Line level of bit i of the frame for byte d on instance k.
    function automatic bit line_bit(input int k, input logic [7:0] d, input int i);
        int ones;
        ones = $countones(d);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (k != 0 && i == 9) return (k == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
        return 1'b1;
    endfunction

    function automatic int find_exp(input int k);
        for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].k == k) return i;
        return -1;
    endfunction

    task automatic monitor(input int k);
        longint prev_end = -100;
        bit     just_ended = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_end   = -100;
                just_ended = 1'b0;
            end else if (tx_w[k] == 1'b1) begin
                if (just_ended)
                    check(busy_w[k] == 1'b0, $sformatf("dut%0d idle_busy", k),
                          longint'(busy_w[k]), 0);
                just_ended = 1'b0;
            end else begin
                int     idx;
                exp_t   e;
                longint exp_start;
                bit     aborted = 1'b0;
                bit     busy_bad = 1'b0;
                bit     rdy_bad = 1'b0;
                int     bad_bit = -1;
                int     bad_off = 0;
                bit     bad_act = 1'b0;
                just_ended = 1'b0;
                idx = find_exp(k);
                if (idx < 0) begin
                    check(1'b0, $sformatf("dut%0d unexpected_frame", k), cyc, -1);
                    for (int w = 0; w < 20 * CPB && busy_w[k] && !reset; w++) @(negedge clk);
                end else begin
                    e = exp_q[idx];
                    exp_q.delete(idx);
                    exp_start = (e.acc > prev_end + 1) ? e.acc : prev_end + 1;
                    check(cyc == exp_start, $sformatf("dut%0d start_cycle data=0x%02h", k, e.d),
                          cyc, exp_start);
`ifdef UART_TX_HOLD_EN
                    check(ready_w[k] == 1'b1, $sformatf("dut%0d ready_at_start", k),
                          longint'(ready_w[k]), 1);
`endif
                    for (int i = 0; i < frame_bits(k) && !aborted; i++) begin
                        for (int c = 0; c < CPB && !aborted; c++) begin
                            if (i != 0 || c != 0) begin
                                @(negedge clk);
                                if (reset) aborted = 1'b1;
                            end
                            if (!aborted) begin
                                if (tx_w[k] != line_bit(k, e.d, i) && bad_bit < 0) begin
                                    bad_bit = i;
                                    bad_off = c;
                                    bad_act = tx_w[k];
                                end
                                if (!busy_w[k]) busy_bad = 1'b1;
`ifndef UART_TX_HOLD_EN
                                if (ready_w[k]) rdy_bad = 1'b1;
`endif
                            end
                        end
                    end
                    if (aborted) begin
                        prev_end = -100;
                    end else begin
                        check(bad_bit < 0, $sformatf("dut%0d frame data=0x%02h bit %0d offset %0d",
                              k, e.d, bad_bit, bad_off), longint'(bad_act),
                              longint'(!bad_act));
                        check(!busy_bad, $sformatf("dut%0d busy_in_frame", k),
                              longint'(busy_bad), 0);
`ifndef UART_TX_HOLD_EN
                        check(!rdy_bad, $sformatf("dut%0d ready_low_in_frame", k),
                              longint'(rdy_bad), 0);
`endif
                        prev_end   = cyc;
                        just_ended = 1'b1;
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic drive(input int k, input int n, input bit fixed, input logic [7:0] fb);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            int gap;
            int waited = 0;
            if (fixed) b = fb;
            else if (i == 0) b = 8'hA5;
            else if (i == 1) b = 8'h00;
            else if (i == 2) b = 8'hFF;
            else b = 8'($urandom);
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 * CPB)) : 0;
            if (gap > 0) begin
                valid_r[k] = 1'b0;
                data_r[k]  = 8'($urandom);
                repeat (gap) @(negedge clk);
            end
            valid_r[k] = 1'b1;
            while (!ready_w[k] && waited < 600) begin
                data_r[k] = 8'($urandom);  // must not be captured while ready is low
                @(negedge clk);
                waited++;
            end
            if (!ready_w[k]) begin
                check(1'b0, $sformatf("dut%0d accept_timeout", k), waited, 600);
                valid_r[k] = 1'b0;
                return;
            end
            data_r[k] = b;
            exp_q.push_back('{k: k, d: b, acc: cyc + 1});
            @(negedge clk);
            data_r[k] = 8'($urandom);
        end
        valid_r[k] = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || busy_w != 3'b000) && w < 4000) begin
            @(negedge clk);
            w++;
        end
        check(exp_q.size() == 0 && busy_w == 3'b000, "drain_pending",
              longint'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        longint s;
        valid_r = 3'b000;
        foreach (data_r[i]) data_r[i] = 8'h00;

        #1 reset = 1'b1;
        #1;
        check(tx_w == 3'b111, "reset_tx_async", longint'(tx_w), 7);
        check(busy_w == 3'b000, "reset_busy_async", longint'(busy_w), 0);
        check(ready_w == 3'b000, "reset_ready", longint'(ready_w), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check(ready_w == 3'b111, "ready_after_release", longint'(ready_w), 7);

        fork
            drive(0, NFR, 1'b0, 8'h00);
            drive(1, NFR, 1'b0, 8'h00);
            drive(2, NFR, 1'b0, 8'h00);
        join
        drain();

        // Abort a frame in data bit 3; the byte must never reappear on the line.
        @(negedge clk);
        check(ready_w == 3'b111, "ready_idle_before_abort", longint'(ready_w), 7);
        foreach (data_r[i]) data_r[i] = 8'h96;
        valid_r = 3'b111;
        for (int k = 0; k < 3; k++) exp_q.push_back('{k: k, d: 8'h96, acc: cyc + 1});
        s = cyc + 1;
        @(negedge clk);
        valid_r = 3'b000;
        while (cyc < s + 4 * CPB + 5) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check(tx_w == 3'b111, "abort_tx_high", longint'(tx_w), 7);
        check(busy_w == 3'b000, "abort_busy_low", longint'(busy_w), 0);
        check(ready_w == 3'b000, "abort_ready_low", longint'(ready_w), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check(ready_w == 3'b111, "ready_after_abort", longint'(ready_w), 7);
        repeat (3 * CPB) @(negedge clk);
        check(tx_w == 3'b111 && busy_w == 3'b000, "no_resend", longint'(busy_w), 0);

        fork
            drive(0, 1, 1'b1, 8'h3C);
            drive(1, 1, 1'b1, 8'h3C);
            drive(2, 1, 1'b1, 8'h3C);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
